// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op and state
// encodings, special-case result constants and a small helper.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MUL   = 3'd0,
        MD_MULH  = 3'd1,
        MD_MULHU = 3'd2,
        MD_RSV   = 3'd3,   // reserved, executes as MD_MUL
        MD_DIV   = 3'd4,
        MD_MOD   = 3'd5,
        MD_DIVU  = 3'd6,
        MD_MODU  = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

    localparam logic [31:0] DIV0_QUO = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN  = 32'h8000_0000;

    // Magnitude of a 32-bit value; only negates when treated as signed.
    function automatic logic [31:0] abs_val(input logic [31:0] v, input logic is_signed);
        logic [31:0] r;
        if (is_signed && v[31]) begin
            r = 32'd0 - v;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// ID/EX-side handshake bundle of the multiply/divide unit.
// slave: the unit itself; master: the pipeline (or a testbench) driving it.
interface ex_muldiv_if #(parameter int XLEN = 32);
    logic            flush_i;
    logic            start_i;
    logic [2:0]      op_i;
    logic [XLEN-1:0] src1_i;
    logic [XLEN-1:0] src2_i;
    logic [4:0]      rd_i;
    logic            stall_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;
    logic [4:0]      rd_o;
    logic            busy_o;

    modport slave (
        input  flush_i, start_i, op_i, src1_i, src2_i, rd_i,
        output stall_o, done_o, result_o, rd_o, busy_o
    );

    modport master (
        output flush_i, start_i, op_i, src1_i, src2_i, rd_i,
        input  stall_o, done_o, result_o, rd_o, busy_o
    );
endinterface

// File: rtl/ex_muldiv_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic            dvd_bit_i,
    input  logic [XLEN-1:0] dvs_i,
    output logic [XLEN-1:0] rem_o,
    output logic            quo_bit_o
);

    logic [XLEN:0]   shifted_s;
    logic [XLEN+1:0] diff_s;

    // Trial subtraction; a borrow means the divisor does not fit this step.
    always_comb begin
        shifted_s = {rem_i, dvd_bit_i};
        diff_s    = {1'b0, shifted_s} - {2'b00, dvs_i};
        if (diff_s[XLEN+1] == 1'b0) begin
            rem_o     = diff_s[XLEN-1:0];
            quo_bit_o = 1'b1;
        end else begin
            rem_o     = shifted_s[XLEN-1:0];
            quo_bit_o = 1'b0;
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit for the EX stage (LoongArch32 MUL.W,
// MULH.W, MULH.WU, DIV.W, MOD.W, DIV.WU, MOD.WU). Multiplies finish in one
// working cycle, divides in DIV_ITERS restoring steps; the result is
// registered and flagged by a one-cycle done_o in the DONE state.
// Optional build macro: MULDIV_FAST_SPECIAL_EN -- divide-by-zero and signed
// overflow are resolved in the single-cycle MUL path instead of iterating.
module ex_muldiv
    import muldiv_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int DIV_ITERS = XLEN
) (
    input  logic        clk,
    input  logic        rst,
    ex_muldiv_if.slave  bus
);

    localparam int CNT_W = (DIV_ITERS > 1) ? $clog2(DIV_ITERS) : 1;

    md_state_e       state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [XLEN-1:0] src1_q, src1_d;
    logic [XLEN-1:0] src2_q, src2_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dvd_q, dvd_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            special_q, special_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [4:0]      rd_out_q, rd_out_d;

    logic            accept_s, in_div_s, in_signed_s, div0_s, ovf_s, fast_s;
    logic            q_signed_s, q_mod_s, a_neg_s, b_neg_s, sext_s;
    logic [XLEN-1:0] step_rem_s, quo_raw_s, quo_fix_s, rem_fix_s;
    logic            step_bit_s;
    logic [XLEN-1:0] special_res_s, div_res_s, mul_res_s;
    logic [2*XLEN-1:0] ext_a_s, ext_b_s, prod_s;
    logic            stall_s, done_s, busy_s;

    assign accept_s    = (state_q == ST_IDLE) && bus.start_i && !bus.flush_i;
    assign in_div_s    = bus.op_i[2];
    assign in_signed_s = ~bus.op_i[1];
    assign div0_s      = (bus.src2_i == {XLEN{1'b0}});
    assign ovf_s       = in_signed_s && (bus.src1_i == INT_MIN) && (bus.src2_i == {XLEN{1'b1}});

`ifdef MULDIV_FAST_SPECIAL_EN
    assign fast_s = in_div_s && (div0_s || ovf_s);
`else
    assign fast_s = 1'b0;
`endif

    assign q_signed_s = ~op_q[1];
    assign q_mod_s    = op_q[0];
    assign a_neg_s    = q_signed_s & src1_q[XLEN-1];
    assign b_neg_s    = q_signed_s & src2_q[XLEN-1];

    div_step #(.XLEN(XLEN)) u_div_step (
        .rem_i     (rem_q),
        .dvd_bit_i (dvd_q[XLEN-1]),
        .dvs_i     (dvs_q),
        .rem_o     (step_rem_s),
        .quo_bit_o (step_bit_s)
    );

    assign quo_raw_s = {dvd_q[XLEN-2:0], step_bit_s};

    // Final-step sign fixup and special-case selection for divides.
    always_comb begin
        if (a_neg_s ^ b_neg_s) begin
            quo_fix_s = {XLEN{1'b0}} - quo_raw_s;
        end else begin
            quo_fix_s = quo_raw_s;
        end
        if (a_neg_s) begin
            rem_fix_s = {XLEN{1'b0}} - step_rem_s;
        end else begin
            rem_fix_s = step_rem_s;
        end
        if (src2_q == {XLEN{1'b0}}) begin
            special_res_s = q_mod_s ? src1_q : DIV0_QUO;
        end else begin
            special_res_s = q_mod_s ? {XLEN{1'b0}} : INT_MIN;
        end
        if (special_q) begin
            div_res_s = special_res_s;
        end else begin
            div_res_s = q_mod_s ? rem_fix_s : quo_fix_s;
        end
    end

    // 64-bit product from operands extended per op; pick low or high word.
    always_comb begin
        sext_s  = (op_q != MD_MULHU);
        ext_a_s = {{XLEN{sext_s & src1_q[XLEN-1]}}, src1_q};
        ext_b_s = {{XLEN{sext_s & src2_q[XLEN-1]}}, src2_q};
        prod_s  = ext_a_s * ext_b_s;
        if ((op_q == MD_MULH) || (op_q == MD_MULHU)) begin
            mul_res_s = prod_s[2*XLEN-1:XLEN];
        end else begin
            mul_res_s = prod_s[XLEN-1:0];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides every state.
    always_comb begin
        state_d = state_q;
        if (bus.flush_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_d = (!in_div_s || fast_s) ? ST_MUL : ST_DIV;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_MUL:  state_d = ST_DONE;
                ST_DIV: begin
                    if (cnt_q == {CNT_W{1'b0}}) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DIV;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        stall_s = 1'b0;
        done_s  = 1'b0;
        busy_s  = 1'b1;
        case (state_q)
            ST_IDLE: begin
                stall_s = bus.start_i;
                busy_s  = 1'b0;
            end
            ST_MUL:  stall_s = 1'b1;
            ST_DIV:  stall_s = 1'b1;
            ST_DONE: done_s  = 1'b1;
            default: begin
                stall_s = 1'b0;
                busy_s  = 1'b0;
            end
        endcase
    end

    // Operand capture, division iteration and result/destination update.
    always_comb begin
        op_d      = op_q;
        src1_d    = src1_q;
        src2_d    = src2_q;
        rd_d      = rd_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        special_d = special_q;
        result_d  = result_q;
        rd_out_d  = rd_out_q;
        if (bus.flush_i) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        op_d      = bus.op_i;
                        src1_d    = bus.src1_i;
                        src2_d    = bus.src2_i;
                        rd_d      = bus.rd_i;
                        rem_d     = {XLEN{1'b0}};
                        dvd_d     = abs_val(bus.src1_i, in_signed_s);
                        dvs_d     = abs_val(bus.src2_i, in_signed_s);
                        cnt_d     = CNT_W'(DIV_ITERS - 1);
                        special_d = in_div_s & (div0_s | ovf_s);
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                ST_MUL: begin
                    // A divide only reaches MUL via the fast special path.
                    result_d = op_q[2] ? special_res_s : mul_res_s;
                    rd_out_d = rd_q;
                end
                ST_DIV: begin
                    rem_d = step_rem_s;
                    dvd_d = quo_raw_s;
                    if (cnt_q == {CNT_W{1'b0}}) begin
                        result_d = div_res_s;
                        rd_out_d = rd_q;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_DONE: cnt_d = cnt_q;
                default: cnt_d = {CNT_W{1'b0}};
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= 3'd0;
            src1_q    <= {XLEN{1'b0}};
            src2_q    <= {XLEN{1'b0}};
            rd_q      <= 5'd0;
            rem_q     <= {XLEN{1'b0}};
            dvd_q     <= {XLEN{1'b0}};
            dvs_q     <= {XLEN{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            special_q <= 1'b0;
            result_q  <= {XLEN{1'b0}};
            rd_out_q  <= 5'd0;
        end else begin
            op_q      <= op_d;
            src1_q    <= src1_d;
            src2_q    <= src2_d;
            rd_q      <= rd_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            special_q <= special_d;
            result_q  <= result_d;
            rd_out_q  <= rd_out_d;
        end
    end

    assign bus.stall_o  = stall_s;
    assign bus.done_o   = done_s;
    assign bus.busy_o   = busy_s;
    assign bus.result_o = result_q;
    assign bus.rd_o     = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Testbench for ex_muldiv: directed plan cases plus randomized operations
// compared against an arithmetic reference model.
module tb_ex_muldiv;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ex_muldiv_if #(.XLEN(32)) bus ();

    ex_muldiv #(.XLEN(32), .DIV_ITERS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef MULDIV_FAST_SPECIAL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] last_res    = 32'd0;
    logic [4:0]  last_rd     = 5'd0;

    // Architectural result of one operation.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, r;
        logic [63:0] up;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        up = {32'd0, a} * {32'd0, b};
        case (op)
            3'd0, 3'd3: begin r = sa * sb; return r[31:0]; end
            3'd1:       begin r = sa * sb; return r[63:32]; end
            3'd2:       return up[63:32];
            3'd4:       begin if (b == 32'd0) return 32'hFFFF_FFFF; r = sa / sb; return r[31:0]; end
            3'd5:       begin if (b == 32'd0) return a; r = sa % sb; return r[31:0]; end
            3'd6:       begin if (b == 32'd0) return 32'hFFFF_FFFF; return a / b; end
            default:    begin if (b == 32'd0) return a; return a % b; end
        endcase
    endfunction

    // Cycle (start = 0) on which done_o is expected.
    function automatic int exp_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] == 1'b0) return 2;
        if (FAST && ((b == 32'd0) || (!op[1] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 2;
        return 33;
    endfunction

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input string name);
        int lat;
        int done_c;
        lat    = exp_latency(op, a, b);
        done_c = 0;
        @(posedge clk); #1;
        bus.start_i = 1'b1; bus.flush_i = 1'b0;
        bus.op_i = op; bus.src1_i = a; bus.src2_i = b; bus.rd_i = rd;
        #1;
        vectors++;
        if (bus.stall_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
            miscompares++;
            $display("FAIL %s accept: stall=%b busy=%b done=%b, required 1 0 0", name, bus.stall_o, bus.busy_o, bus.done_o);
        end
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #2;
            if (bus.done_o === 1'b1) begin
                done_c = c;
                break;
            end
            vectors++;
            if (bus.stall_o !== 1'b1 || bus.result_o !== last_res) begin
                miscompares++;
                $display("FAIL %s busy cycle %0d: stall=%b result=%h, required 1 %h", name, c, bus.stall_o, bus.result_o, last_res);
            end
        end
        vectors++;
        if (done_c == 0) begin
            miscompares++;
            $display("FAIL %s timeout: no done_o within 40 cycles, required cycle %0d", name, lat);
        end else begin
            if (done_c != lat) begin
                miscompares++;
                $display("FAIL %s latency: done at cycle %0d, required %0d", name, done_c, lat);
            end
            vectors++;
            if (bus.result_o !== exp) begin
                miscompares++;
                $display("FAIL %s result: got %h, required %h", name, bus.result_o, exp);
            end
            vectors++;
            if (bus.rd_o !== rd || bus.stall_o !== 1'b0) begin
                miscompares++;
                $display("FAIL %s done: rd=%0d stall=%b, required %0d 0", name, bus.rd_o, bus.stall_o, rd);
            end
        end
        last_res = exp;
        last_rd  = rd;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.start_i = 1'b0;
            #1;
            vectors++;
            if (bus.stall_o !== 1'b0 || bus.done_o !== 1'b0 || bus.busy_o !== 1'b0 ||
                bus.result_o !== last_res || bus.rd_o !== last_rd) begin
                miscompares++;
                $display("FAIL idle hold: stall=%b done=%b busy=%b result=%h rd=%0d, required 0 0 0 %h %0d",
                         bus.stall_o, bus.done_o, bus.busy_o, bus.result_o, bus.rd_o, last_res, last_rd);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start_i = 1'b0; bus.flush_i = 1'b0; bus.op_i = 3'd0;
        bus.src1_i = 32'd0; bus.src2_i = 32'd0; bus.rd_i = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (bus.stall_o !== 1'b0 || bus.done_o !== 1'b0 || bus.busy_o !== 1'b0 ||
            bus.result_o !== 32'd0 || bus.rd_o !== 5'd0) begin
            miscompares++;
            $display("FAIL reset: stall=%b done=%b busy=%b result=%h rd=%0d, required all 0",
                     bus.stall_o, bus.done_o, bus.busy_o, bus.result_o, bus.rd_o);
        end
        rst = 1'b0;
        last_res = 32'd0;
        last_rd  = 5'd0;
    endtask

    task automatic test_directed();
        do_op(MD_MUL,   32'd7,         32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, "mul");
        do_op(MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, "mulhu");
        do_op(MD_MULH,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'h0000_0000, "mulh");
        do_op(MD_DIV,   32'hFFFF_FFF9, 32'd2,         5'd4, 32'hFFFF_FFFD, "div");
        do_op(MD_MOD,   32'hFFFF_FFF9, 32'd2,         5'd5, 32'hFFFF_FFFF, "mod");
        idle(2);
    endtask

    task automatic test_corner();
        do_op(MD_DIVU, 32'd5,         32'd0,         5'd6,  32'hFFFF_FFFF, "divu_by0");
        do_op(MD_MODU, 32'd5,         32'd0,         5'd7,  32'd5,         "modu_by0");
        do_op(MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd8,  32'h8000_0000, "div_ovf");
        do_op(MD_MOD,  32'h8000_0000, 32'hFFFF_FFFF, 5'd9,  32'd0,         "mod_ovf");
        do_op(MD_DIV,  32'hFFFF_FFF9, 32'd0,         5'd10, 32'hFFFF_FFFF, "div_neg_by0");
        do_op(MD_MOD,  32'hFFFF_FFF9, 32'd0,         5'd11, 32'hFFFF_FFF9, "mod_neg_by0");
        do_op(MD_RSV,  32'h1234_5678, 32'h10,        5'd12, 32'h2345_6780, "rsv_as_mul");
        idle(1);
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 20));
                3: b = -32'($urandom_range(1, 20));
                default: ;
            endcase
            do_op(op, a, b, 5'($urandom_range(0, 31)), model(op, a, b), "random");
            idle($urandom_range(0, 2));
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = $urandom;
            do_op(3'(i + 2), a, b, 5'(i + 20), model(3'(i + 2), a, b), "b2b");
        end
        idle(1);
    endtask

    task automatic test_flush();
        @(posedge clk); #1;
        bus.start_i = 1'b1; bus.flush_i = 1'b0;
        bus.op_i = MD_DIV; bus.src1_i = 32'd100; bus.src2_i = 32'd7; bus.rd_i = 5'd9;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            vectors++;
            if (bus.done_o !== 1'b0 || bus.stall_o !== 1'b1) begin
                miscompares++;
                $display("FAIL flush pre cycle %0d: done=%b stall=%b, required 0 1", c, bus.done_o, bus.stall_o);
            end
            if (c == 10) bus.flush_i = 1'b1;
        end
        @(posedge clk); #1;
        bus.flush_i = 1'b0; bus.start_i = 1'b0;
        #1;
        vectors++;
        if (bus.stall_o !== 1'b0 || bus.done_o !== 1'b0 || bus.busy_o !== 1'b0 ||
            bus.result_o !== last_res || bus.rd_o !== last_rd) begin
            miscompares++;
            $display("FAIL flush cycle 11: stall=%b done=%b busy=%b result=%h rd=%0d, required 0 0 0 %h %0d",
                     bus.stall_o, bus.done_o, bus.busy_o, bus.result_o, bus.rd_o, last_res, last_rd);
        end
        bus.start_i = 1'b1; bus.op_i = MD_MUL; bus.src1_i = 32'd12; bus.src2_i = 32'd11; bus.rd_i = 5'd17;
        @(posedge clk); #2;
        vectors++;
        if (bus.done_o !== 1'b0 || bus.stall_o !== 1'b1) begin
            miscompares++;
            $display("FAIL flush mul cycle 12: done=%b stall=%b, required 0 1", bus.done_o, bus.stall_o);
        end
        @(posedge clk); #2;
        vectors++;
        if (bus.done_o !== 1'b1 || bus.result_o !== 32'd132 || bus.rd_o !== 5'd17) begin
            miscompares++;
            $display("FAIL flush mul cycle 13: done=%b result=%h rd=%0d, required 1 00000084 17",
                     bus.done_o, bus.result_o, bus.rd_o);
        end
        last_res = 32'd132;
        last_rd  = 5'd17;
        idle(1);
    endtask

    task automatic test_rst_mid();
        logic [31:0] a, b;
        @(posedge clk); #1;
        bus.start_i = 1'b1; bus.flush_i = 1'b0;
        bus.op_i = MD_DIV; bus.src1_i = 32'd1000; bus.src2_i = 32'd3; bus.rd_i = 5'd4;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            if (c == 5) begin
                rst = 1'b1;
                bus.start_i = 1'b0;
            end
        end
        @(posedge clk); #1;
        vectors++;
        if (bus.stall_o !== 1'b0 || bus.done_o !== 1'b0 || bus.busy_o !== 1'b0 ||
            bus.result_o !== 32'd0 || bus.rd_o !== 5'd0) begin
            miscompares++;
            $display("FAIL reset mid-div: stall=%b done=%b busy=%b result=%h rd=%0d, required all 0",
                     bus.stall_o, bus.done_o, bus.busy_o, bus.result_o, bus.rd_o);
        end
        rst = 1'b0;
        last_res = 32'd0;
        last_rd  = 5'd0;
        a = $urandom;
        b = $urandom;
        do_op(MD_MULH, a, b, 5'd30, model(MD_MULH, a, b), "after_rst");
        do_op(MD_DIVU, a, b | 32'd1, 5'd31, model(MD_DIVU, a, b | 32'd1), "after_rst_div");
        idle(1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_corner();
        test_back_to_back();
        test_flush();
        test_rst_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
